alarma_ctrl: RTL and testbench
==============================

ALARMA_CTRL -- requirements
Module: alarma_ctrl

Interface
REQ-001 SHALL have parameter N_ZONAS, default 3, meaning the number of sensor zones (1..16).
REQ-002 SHALL have parameter T_SALIDA, default 8, meaning the exit-delay length in clk cycles (>=1).
REQ-003 SHALL have parameter T_ENTRADA, default 8, meaning the entry-delay length in clk cycles (>=1).
REQ-004 SHALL have parameter MASK_RETARDO, default 3'b001, meaning the zones routed through the entry delay (all other zones are immediate).
REQ-005 SHALL derive localparam CW = clog2(max(T_SALIDA,T_ENTRADA)+1).
REQ-006 SHALL have port clk, input, 1, system clock, rising edge; one clock only.
REQ-007 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-008 SHALL have port armar, input, 1, arm request (level, sampled each cycle).
REQ-009 SHALL have port desarmar, input, 1, disarm request (level, sampled each cycle).
REQ-010 SHALL have port zonas, input, N_ZONAS, raw sensor levels, 1 = tripped.
REQ-011 SHALL have port habilitar, input, N_ZONAS, per-zone enable, 0 = bypassed.
REQ-012 SHALL have port alarma, output, 1, siren, registered.
REQ-013 SHALL have port armado, output, 1, system armed (ARMADO, ENTRADA or ALARMA), registered.
REQ-014 SHALL have port estado, output, 3, current FSM state code.
REQ-015 SHALL have port zona_disparo, output, N_ZONAS, latched record of the zones that tripped.
REQ-016 SHALL have port cuenta, output, CW, remaining delay cycles, registered.

Function
REQ-017 SHALL implement an FSM with the following state codes: DESARMADO=0, SALIDA=1, ARMADO=2, ENTRADA=3, ALARMA=4; codes 5..7 SHALL return to DESARMADO on the next cycle.
REQ-018 SHALL define activas = zonas & habilitar; immediate = activas & ~MASK_RETARDO; delayed = activas & MASK_RETARDO.
REQ-019 SHALL, in DESARMADO with armar=1 and desarmar=0, go to SALIDA, load cuenta=T_SALIDA, and clear zona_disparo.
REQ-020 SHALL, in SALIDA, decrement cuenta each cycle and ignore zones; when cuenta==1 it SHALL go to ARMADO with cuenta=0, so SALIDA lasts exactly T_SALIDA cycles.
REQ-021 SHALL, in ARMADO with immediate!=0, go to ALARMA on the next edge; else with delayed!=0, go to ENTRADA with cuenta=T_ENTRADA; in both cases zona_disparo |= activas.
REQ-022 SHALL, in ENTRADA, decrement cuenta each cycle; on immediate!=0 or cuenta==1 it SHALL go to ALARMA (ENTRADA lasts at most T_ENTRADA cycles).
REQ-023 SHALL, in ENTRADA and ALARMA, OR activas into zona_disparo every cycle.
REQ-024 SHALL latch ALARMA with alarma=1 regardless of later zone levels, until desarmar.
REQ-025 SHALL, on desarmar=1 in any state, go to DESARMADO next cycle with cuenta=0 and alarma=0, while zona_disparo is retained.
REQ-026 SHALL give desarmar priority when armar and desarmar are both 1; armar SHALL be ignored outside DESARMADO.
REQ-027 SHALL make alarma, armado, estado and cuenta pure register outputs (no combinational path from inputs); the latency from zone trip to alarma for an immediate zone in ARMADO SHALL be 1 cycle.
REQ-028 SHALL reject T_SALIDA<1, T_ENTRADA<1 or N_ZONAS outside 1..16 at elaboration.

Reset
REQ-029 SHALL, with reset=1 at a clk edge, set estado=DESARMADO, alarma=0, armado=0, cuenta=0, zona_disparo=0; reset overrides all inputs, including mid-delay and mid-alarm.

Structure
REQ-030 SHALL place the state codes and the CW width function in a shared package, alarma_pkg.
REQ-031 SHALL instantiate one sub-module, contador_desc (loadable down-counter: load, value, en, zero flag), used for both delays.

Verification (N_ZONAS=3, T_SALIDA=4, T_ENTRADA=3, MASK_RETARDO=3'b001, habilitar=3'b111)
REQ-032 SHALL verify arming: pulse armar at t0 -> estado=1 for 4 cycles with cuenta 4,3,2,1, then estado=2, armado=1.
REQ-033 SHALL verify an immediate zone: in ARMADO, zonas=3'b100 for 1 cycle -> alarma=1 next cycle, zona_disparo=3'b100, alarma held after zonas=0.
REQ-034 SHALL verify the entry delay with disarm: zonas=3'b001, then desarmar on the 2nd ENTRADA cycle -> estado=0, alarma never 1, zona_disparo=3'b001.
REQ-035 SHALL verify entry timeout: zonas=3'b001, no disarm -> alarma=1 exactly 3 cycles after entering ENTRADA; a zone 1 trip during ENTRADA -> alarma the next cycle, zona_disparo=3'b011.
REQ-036 SHALL verify bypass and collision: habilitar=3'b011 with zonas=3'b100 in ARMADO -> no change; armar=desarmar=1 in DESARMADO -> stays 0.
REQ-037 SHALL verify reset in ALARMA and SALIDA -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/alarma_pkg.sv
// Shared definitions for the alarm controller: state codes and counter width helper.
package alarma_pkg;

  typedef enum logic [2:0] {
    DESARMADO = 3'd0,
    SALIDA    = 3'd1,
    ARMADO    = 3'd2,
    ENTRADA   = 3'd3,
    ALARMA    = 3'd4
  } state_t;

  // Width needed to hold the longer of the two delays.
  function automatic int cw_width(input int t_salida, input int t_entrada);
    int mx;
    mx = (t_salida > t_entrada) ? t_salida : t_entrada;
    return $clog2(mx + 1);
  endfunction

endpackage

// File: rtl/contador_desc.sv
// Loadable down-counter shared by the exit and entry delays; stops at zero.
module contador_desc #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/alarma_ctrl.sv
// Intruder alarm controller: exit delay, armed watch, entry delay and latched siren.
module alarma_ctrl
  import alarma_pkg::*;
#(
  parameter int          N_ZONAS      = 3,
  parameter int          T_SALIDA     = 8,
  parameter int          T_ENTRADA    = 8,
  parameter logic [15:0] MASK_RETARDO = 16'b001,
  localparam int         CW           = cw_width(T_SALIDA, T_ENTRADA)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               armar,
  input  logic               desarmar,
  input  logic [N_ZONAS-1:0] zonas,
  input  logic [N_ZONAS-1:0] habilitar,
  output logic               alarma,
  output logic               armado,
  output logic [2:0]         estado,
  output logic [N_ZONAS-1:0] zona_disparo,
  output logic [CW-1:0]      cuenta
);

  generate
    if (N_ZONAS < 1 || N_ZONAS > 16) begin : g_bad_zonas
      $error("alarma_ctrl: N_ZONAS must be in 1..16");
    end
    if (T_SALIDA < 1 || T_ENTRADA < 1) begin : g_bad_delay
      $error("alarma_ctrl: T_SALIDA and T_ENTRADA must be >= 1");
    end
  endgenerate

  localparam logic [N_ZONAS-1:0] MASK = MASK_RETARDO[N_ZONAS-1:0];

  state_t              state_reg;
  logic [N_ZONAS-1:0]  activas;
  logic [N_ZONAS-1:0]  immediate;
  logic [N_ZONAS-1:0]  delayed;
  logic                ctr_load;
  logic [CW-1:0]       ctr_value;
  logic                ctr_en;
  logic                ctr_zero;
  logic                last_cycle;

  assign activas    = zonas & habilitar;
  assign immediate  = activas & ~MASK;
  assign delayed    = activas & MASK;
  assign estado     = state_reg;
  // A zero count while still in a delay state is treated as expiry so the FSM can never stall.
  assign last_cycle = (cuenta == CW'(1)) || ctr_zero;

  always_comb begin
    ctr_load  = 1'b0;
    ctr_value = '0;
    ctr_en    = 1'b0;
    if (desarmar) begin
      ctr_load = 1'b1;
    end else begin
      case (state_reg)
        DESARMADO: begin
          if (armar) begin
            ctr_load  = 1'b1;
            ctr_value = CW'(T_SALIDA);
          end
        end
        SALIDA:  ctr_en = 1'b1;
        ARMADO: begin
          if (immediate == '0 && delayed != '0) begin
            ctr_load  = 1'b1;
            ctr_value = CW'(T_ENTRADA);
          end
        end
        ENTRADA: begin
          if (immediate != '0) ctr_load = 1'b1;
          else                 ctr_en   = 1'b1;
        end
        default: ctr_load = 1'b1;
      endcase
    end
  end

  contador_desc #(.W(CW)) u_contador (
    .clk   (clk),
    .reset (reset),
    .load  (ctr_load),
    .value (ctr_value),
    .en    (ctr_en),
    .count (cuenta),
    .zero  (ctr_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= DESARMADO;
      alarma       <= 1'b0;
      armado       <= 1'b0;
      zona_disparo <= '0;
    end else if (desarmar) begin
      state_reg <= DESARMADO;
      alarma    <= 1'b0;
      armado    <= 1'b0;
    end else begin
      case (state_reg)
        DESARMADO: begin
          if (armar) begin
            state_reg    <= SALIDA;
            zona_disparo <= '0;
          end
        end
        SALIDA: begin
          if (last_cycle) begin
            state_reg <= ARMADO;
            armado    <= 1'b1;
          end
        end
        ARMADO: begin
          zona_disparo <= zona_disparo | activas;
          if (immediate != '0) begin
            state_reg <= ALARMA;
            alarma    <= 1'b1;
          end else if (delayed != '0) begin
            state_reg <= ENTRADA;
          end
        end
        ENTRADA: begin
          zona_disparo <= zona_disparo | activas;
          if (immediate != '0 || last_cycle) begin
            state_reg <= ALARMA;
            alarma    <= 1'b1;
          end
        end
        ALARMA: begin
          zona_disparo <= zona_disparo | activas;
          alarma       <= 1'b1;
        end
        default: begin
          state_reg <= DESARMADO;
          alarma    <= 1'b0;
          armado    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alarma_ctrl.sv
// Directed bench for alarma_ctrl with short delays (exit 4, entry 3, zone 0 delayed).
module tb_alarma_ctrl;

  logic       clk;
  logic       reset;
  logic       armar;
  logic       desarmar;
  logic [2:0] zonas;
  logic [2:0] habilitar;
  logic       alarma;
  logic       armado;
  logic [2:0] estado;
  logic [2:0] zona_disparo;
  logic [2:0] cuenta;

  int checks = 0;
  int errors = 0;

  alarma_ctrl #(
    .N_ZONAS     (3),
    .T_SALIDA    (4),
    .T_ENTRADA   (3),
    .MASK_RETARDO(16'b001)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .armar       (armar),
    .desarmar    (desarmar),
    .zonas       (zonas),
    .habilitar   (habilitar),
    .alarma      (alarma),
    .armado      (armado),
    .estado      (estado),
    .zona_disparo(zona_disparo),
    .cuenta      (cuenta)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm_up();
    armar = 1'b1;
    tick();
    armar = 1'b0;
    repeat (4) tick();
    check("arm_up_estado", 32'(estado), 32'd2);
  endtask

  task automatic disarm();
    desarmar = 1'b1;
    tick();
    desarmar = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_estado"}, 32'(estado), 32'd0);
    check({tag, "_alarma"}, 32'(alarma), 32'd0);
    check({tag, "_armado"}, 32'(armado), 32'd0);
    check({tag, "_cuenta"}, 32'(cuenta), 32'd0);
    check({tag, "_zona"},   32'(zona_disparo), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    armar     = 1'b0;
    desarmar  = 1'b0;
    zonas     = 3'b000;
    habilitar = 3'b111;
    tick();
    tick();
    reset = 1'b0;
    check_all_zero("reset");

    // Arming: four exit cycles counting 4,3,2,1, then armed.
    armar = 1'b1;
    tick();
    armar = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("salida_estado", 32'(estado), 32'd1);
      check("salida_cuenta", 32'(cuenta), 32'(4 - i));
      tick();
    end
    check("armed_estado", 32'(estado), 32'd2);
    check("armed_armado", 32'(armado), 32'd1);
    check("armed_cuenta", 32'(cuenta), 32'd0);

    // Immediate zone: one-cycle trip, alarm next cycle and held.
    zonas = 3'b100;
    tick();
    zonas = 3'b000;
    check("imm_alarma", 32'(alarma), 32'd1);
    check("imm_estado", 32'(estado), 32'd4);
    check("imm_zona", 32'(zona_disparo), 32'b100);
    tick();
    check("imm_hold", 32'(alarma), 32'd1);
    disarm();
    check("dis_estado", 32'(estado), 32'd0);
    check("dis_alarma", 32'(alarma), 32'd0);
    check("dis_armado", 32'(armado), 32'd0);
    check("dis_zona_kept", 32'(zona_disparo), 32'b100);

    // Entry delay, disarmed on the second entry cycle.
    arm_up();
    zonas = 3'b001;
    tick();
    zonas = 3'b000;
    check("ent1_estado", 32'(estado), 32'd3);
    check("ent1_cuenta", 32'(cuenta), 32'd3);
    check("ent1_alarma", 32'(alarma), 32'd0);
    tick();
    check("ent2_cuenta", 32'(cuenta), 32'd2);
    check("ent2_alarma", 32'(alarma), 32'd0);
    disarm();
    check("entdis_estado", 32'(estado), 32'd0);
    check("entdis_alarma", 32'(alarma), 32'd0);
    check("entdis_zona", 32'(zona_disparo), 32'b001);

    // Entry timeout: alarm exactly 3 cycles after entering ENTRADA.
    arm_up();
    zonas = 3'b001;
    tick();
    zonas = 3'b000;
    check("to1_estado", 32'(estado), 32'd3);
    tick();
    check("to2_alarma", 32'(alarma), 32'd0);
    tick();
    check("to3_estado", 32'(estado), 32'd3);
    check("to3_alarma", 32'(alarma), 32'd0);
    tick();
    check("to_alarma", 32'(alarma), 32'd1);
    check("to_estado", 32'(estado), 32'd4);
    check("to_zona", 32'(zona_disparo), 32'b001);
    disarm();

    // Immediate zone during entry shortens the delay.
    arm_up();
    zonas = 3'b001;
    tick();
    zonas = 3'b010;
    tick();
    zonas = 3'b000;
    check("entimm_alarma", 32'(alarma), 32'd1);
    check("entimm_estado", 32'(estado), 32'd4);
    check("entimm_zona", 32'(zona_disparo), 32'b011);
    disarm();

    // Bypassed zone has no effect.
    arm_up();
    habilitar = 3'b011;
    zonas     = 3'b100;
    tick();
    check("byp_estado", 32'(estado), 32'd2);
    check("byp_alarma", 32'(alarma), 32'd0);
    check("byp_zona", 32'(zona_disparo), 32'b000);
    zonas     = 3'b000;
    habilitar = 3'b111;
    disarm();

    // armar and desarmar together: disarm wins.
    armar    = 1'b1;
    desarmar = 1'b1;
    tick();
    armar    = 1'b0;
    desarmar = 1'b0;
    check("coll_estado", 32'(estado), 32'd0);
    check("coll_cuenta", 32'(cuenta), 32'd0);

    // Reset during alarm.
    arm_up();
    zonas = 3'b100;
    tick();
    zonas = 3'b000;
    check("pre_rst_alarma", 32'(alarma), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_all_zero("rst_alarma");

    // Reset during exit delay.
    armar = 1'b1;
    tick();
    armar = 1'b0;
    tick();
    check("pre_rst_sal_estado", 32'(estado), 32'd1);
    check("pre_rst_sal_cuenta", 32'(cuenta), 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_all_zero("rst_salida");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
